// File: rtl/capture_scheduler.sv
// -----------------------------------------------------------------------------
// capture_scheduler
//
// Sequences frame captures for the two Stonyman camera channels. Issues
// one-cycle frame_capture_start pulses to cam0, cam1, or alternately to both,
// waits for the selected camera's frame_capture_done, then holds off for a
// programmable inter-frame gap before idling or re-arming.
//
// Optional build macro: SCHED_TIMEOUT_EN
//   defined   : a watchdog counts cycles in WAIT_DONE. After TIMEOUT_CYCLES
//               cycles without the selected done, it sets the sticky
//               timeout_err flag and moves to GAP without counting the frame.
//   undefined : no watchdog. WAIT_DONE waits indefinitely, timeout_err is
//               held at 0 and err_clear is ignored.
//
// Handshake: the start outputs are single-cycle, registered pulses with no
// acknowledge. A start is only issued when the selected camera's busy input
// was low at the issuing edge. A done is honoured only from the selected
// camera, and only while in WAIT_DONE.
//
// Ports:
//   clk                      in   system clock, rising edge
//   reset                    in   synchronous active-low reset
//   enable                   in   scheduler enable
//   continuous               in   1: re-arm after each gap, 0: one frame per trigger
//   mode[1:0]                in   00 cam0, 01 cam1, 1x alternate (cam0 first)
//   period[PERIOD_W-1:0]     in   idle cycles spent in GAP after each frame
//   sw_trigger               in   single-cycle start request (IDLE only)
//   err_clear                in   clears timeout_err (a same-cycle timeout wins)
//   cam0_controller_busy     in   stonyman0 busy
//   cam0_frame_capture_done  in   stonyman0 done pulse
//   cam1_controller_busy     in   stonyman1 busy
//   cam1_frame_capture_done  in   stonyman1 done pulse
//   cam0_frame_capture_start out  one-cycle start pulse to stonyman0
//   cam1_frame_capture_start out  one-cycle start pulse to stonyman1
//   active_cam               out  camera of the current or last frame
//   sched_busy               out  high whenever the FSM is not in IDLE
//   frame_count              out  completed frames, wraps at all-ones
//   timeout_err              out  sticky watchdog flag
//   o_dbg_state[1:0]         out  FSM state (0 IDLE, 1 START, 2 WAIT_DONE, 3 GAP)
// -----------------------------------------------------------------------------
module capture_scheduler #(
   parameter int PERIOD_W       = 16,
   parameter int COUNT_W        = 16,
   parameter int TIMEOUT_CYCLES = 4000000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic                continuous,
   input  logic [1:0]          mode,
   input  logic [PERIOD_W-1:0] period,
   input  logic                sw_trigger,
   input  logic                err_clear,
   input  logic                cam0_controller_busy,
   input  logic                cam0_frame_capture_done,
   input  logic                cam1_controller_busy,
   input  logic                cam1_frame_capture_done,
   output logic                cam0_frame_capture_start,
   output logic                cam1_frame_capture_start,
   output logic                active_cam,
   output logic                sched_busy,
   output logic [COUNT_W-1:0]  frame_count,
   output logic                timeout_err,
   output logic [1:0]          o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_START     = 2'd1,
      S_WAIT_DONE = 2'd2,
      S_GAP       = 2'd3
   } state_t;

   state_t                r_state;
   logic                  r_alt;        // latched mode[1]: alternate cameras
   logic [PERIOD_W-1:0]   r_period;     // latched period
   logic [PERIOD_W-1:0]   r_gap;        // inter-frame gap down-counter
   logic                  r_next_cam;   // camera used by the next alternating frame
   logic                  r_active_cam;
   logic                  r_start0;
   logic                  r_start1;
   logic                  r_busy;
   logic [COUNT_W-1:0]    r_count;
   logic                  r_timeout_err;

   logic                  w_trigger;
   logic                  w_arm_cam;
   logic                  w_sel_busy;
   logic                  w_sel_done;

   // Arming condition shared by IDLE and the GAP re-arm path.
   assign w_trigger  = enable && (sw_trigger || continuous);

   // Camera chosen at the moment of arming. In alternate mode r_next_cam has
   // already been toggled by the previous frame's completion.
   assign w_arm_cam  = mode[1] ? r_next_cam : mode[0];

   // Busy/done of the camera selected for the current frame.
   assign w_sel_busy = r_active_cam ? cam1_controller_busy    : cam0_controller_busy;
   assign w_sel_done = r_active_cam ? cam1_frame_capture_done : cam0_frame_capture_done;

`ifdef SCHED_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   logic [TO_W-1:0]       r_to_cnt;
`else
   // Without the watchdog, err_clear and TIMEOUT_CYCLES have no function.
   logic                  w_unused;
   assign w_unused = err_clear ^ (TIMEOUT_CYCLES < 2);
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_alt         <= 1'b0;
         r_period      <= '0;
         r_gap         <= '0;
         r_next_cam    <= 1'b0;
         r_active_cam  <= 1'b0;
         r_start0      <= 1'b0;
         r_start1      <= 1'b0;
         r_busy        <= 1'b0;
         r_count       <= '0;
         r_timeout_err <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
         r_to_cnt      <= '0;
`endif
      end else begin
         // Start outputs are pulses: low unless set below this cycle.
         r_start0 <= 1'b0;
         r_start1 <= 1'b0;

`ifdef SCHED_TIMEOUT_EN
         // A timeout set later in this block overrides this clear.
         if (err_clear) begin
            r_timeout_err <= 1'b0;
         end
`endif

         case (r_state)
            S_IDLE: begin
               if (w_trigger) begin
                  r_alt        <= mode[1];
                  r_period     <= period;
                  r_active_cam <= w_arm_cam;
                  r_state      <= S_START;
                  r_busy       <= 1'b1;
               end
            end

            S_START: begin
               if (!enable) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else if (!w_sel_busy) begin
                  r_start0 <= ~r_active_cam;
                  r_start1 <= r_active_cam;
                  r_state  <= S_WAIT_DONE;
`ifdef SCHED_TIMEOUT_EN
                  r_to_cnt <= '0;
`endif
               end
            end

            // enable is deliberately ignored here: a Stonyman readout cannot
            // be interrupted, so the frame always runs to completion.
            S_WAIT_DONE: begin
               if (w_sel_done) begin
                  r_count <= r_count + 1'b1;
                  if (r_alt) begin
                     r_next_cam <= ~r_next_cam;
                  end
                  r_gap   <= r_period;
                  r_state <= S_GAP;
               end
`ifdef SCHED_TIMEOUT_EN
               else if (r_to_cnt == TO_LAST) begin
                  // Abandon the frame: flag it, do not count it, but keep the
                  // alternation moving so the other camera gets its turn.
                  r_timeout_err <= 1'b1;
                  if (r_alt) begin
                     r_next_cam <= ~r_next_cam;
                  end
                  r_gap   <= r_period;
                  r_state <= S_GAP;
               end else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
               end
`endif
            end

            S_GAP: begin
               if (!enable) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else if (r_gap == '0) begin
                  if (continuous) begin
                     // Re-arm with freshly sampled configuration.
                     r_alt        <= mode[1];
                     r_period     <= period;
                     r_active_cam <= w_arm_cam;
                     r_state      <= S_START;
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_gap <= r_gap - 1'b1;
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign cam0_frame_capture_start = r_start0;
   assign cam1_frame_capture_start = r_start1;
   assign active_cam               = r_active_cam;
   assign sched_busy               = r_busy;
   assign frame_count              = r_count;
   assign timeout_err              = r_timeout_err;
   assign o_dbg_state              = r_state;

endmodule

// File: tb/tb_capture_scheduler.sv
// -----------------------------------------------------------------------------
// tb_capture_scheduler
//
// Directed bench for capture_scheduler. Each test pushes the start pulses it
// expects ({camera, edge number}) into exp_q; a monitor on the falling edge
// pops and compares every start pulse the DUT emits. Register-level values
// (frame_count, state, flags) are compared at fixed edges just after the
// rising edge. Frame counter is built 8 bits wide so the wrap test stays short.
// -----------------------------------------------------------------------------
module tb_capture_scheduler;

   localparam int PERIOD_W = 16;
   localparam int COUNT_W  = 8;
   localparam int TO_CYC   = 50;

   logic                clk = 1'b0;
   logic                reset;
   logic                enable;
   logic                continuous;
   logic [1:0]          mode;
   logic [PERIOD_W-1:0] period;
   logic                sw_trigger;
   logic                err_clear;
   logic                cam0_busy;
   logic                cam1_busy;
   logic                man_done0, man_done1;
   logic                resp_done0 = 1'b0, resp_done1 = 1'b0;
   logic                cam0_done, cam1_done;
   logic                cam0_start, cam1_start;
   logic                active_cam;
   logic                sched_busy;
   logic [COUNT_W-1:0]  frame_count;
   logic                timeout_err;
   logic [1:0]          dbg_state;

   assign cam0_done = man_done0 | resp_done0;
   assign cam1_done = man_done1 | resp_done1;

   capture_scheduler #(
      .PERIOD_W      (PERIOD_W),
      .COUNT_W       (COUNT_W),
      .TIMEOUT_CYCLES(TO_CYC)
   ) dut (
      .clk                     (clk),
      .reset                   (reset),
      .enable                  (enable),
      .continuous              (continuous),
      .mode                    (mode),
      .period                  (period),
      .sw_trigger              (sw_trigger),
      .err_clear               (err_clear),
      .cam0_controller_busy    (cam0_busy),
      .cam0_frame_capture_done (cam0_done),
      .cam1_controller_busy    (cam1_busy),
      .cam1_frame_capture_done (cam1_done),
      .cam0_frame_capture_start(cam0_start),
      .cam1_frame_capture_start(cam1_start),
      .active_cam              (active_cam),
      .sched_busy              (sched_busy),
      .frame_count             (frame_count),
      .timeout_err             (timeout_err),
      .o_dbg_state             (dbg_state)
   );

   // ---------------- clock / edge counter ----------------
   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // ---------------- scoreboard state ----------------
   int checks   = 0;
   int failures = 0;
   logic [32:0] exp_q[$];   // {cam, edge at which the pulse is registered}

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   task automatic push_start(input logic cam, input int e);
      exp_q.push_back({cam, 32'(e)});
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [32:0] e;
      if (cam0_start || cam1_start) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_start", {30'd0, cam1_start, cam0_start}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("start_cam0", {31'd0, cam0_start}, {31'd0, ~e[32]});
            chk("start_cam1", {31'd0, cam1_start}, {31'd0, e[32]});
            chk("start_edge", 32'(edge_cnt), e[31:0]);
         end
      end
   end

   // ---------------- camera responder ----------------
   logic resp_en    = 1'b0;
   int   resp_delay = 3;

   always begin
      logic rc;
      @(negedge clk);
      if (resp_en && (cam0_start || cam1_start)) begin
         rc = cam1_start;
         repeat (resp_delay - 1) @(posedge clk);
         #1;
         if (rc) resp_done1 = 1'b1;
         else    resp_done0 = 1'b1;
         @(posedge clk);
         #1;
         resp_done0 = 1'b0;
         resp_done1 = 1'b0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int n);
      while (edge_cnt < n) tick();
   endtask

   task automatic do_reset();
      enable     = 1'b1;
      continuous = 1'b0;
      mode       = 2'b00;
      period     = '0;
      sw_trigger = 1'b0;
      err_clear  = 1'b0;
      cam0_busy  = 1'b0;
      cam1_busy  = 1'b0;
      man_done0  = 1'b0;
      man_done1  = 1'b0;
      resp_en    = 1'b0;
      reset      = 1'b0;
      tick();
      tick();
      reset      = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int b;

      // Test 1: reset values, enable+trigger together, single frame
      do_reset();
      b = edge_cnt;
      chk("rst_start0", {31'd0, cam0_start}, 32'd0);
      chk("rst_start1", {31'd0, cam1_start}, 32'd0);
      chk("rst_active_cam", {31'd0, active_cam}, 32'd0);
      chk("rst_busy", {31'd0, sched_busy}, 32'd0);
      chk("rst_count", 32'(frame_count), 32'd0);
      chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
      chk("rst_state", 32'(dbg_state), 32'd0);
      enable = 1'b0;
      wait_until(b + 2);
      sw_trigger = 1'b1;                      // blocked by enable low
      tick();
      sw_trigger = 1'b0;
      chk("t1_blocked_state", 32'(dbg_state), 32'd0);
      wait_until(b + 7);
      enable     = 1'b1;                      // rises with the trigger
      sw_trigger = 1'b1;
      push_start(1'b0, b + 9);
      tick();
      sw_trigger = 1'b0;
      wait_until(b + 9);
      chk("t1_busy", {31'd0, sched_busy}, 32'd1);
      wait_until(b + 11);
      sw_trigger = 1'b1;                      // dropped outside IDLE
      tick();
      sw_trigger = 1'b0;
      wait_until(b + 17);
      man_done0 = 1'b1;
      tick();
      man_done0 = 1'b0;
      chk("t1_count", 32'(frame_count), 32'd1);
      wait_until(b + 20);
      chk("t1_idle_busy", {31'd0, sched_busy}, 32'd0);
      chk("t1_idle_state", 32'(dbg_state), 32'd0);

      // Test 2: alternate, continuous, period 5, dones 3 cycles after start
      do_reset();
      b = edge_cnt;
      mode       = 2'b10;
      period     = 16'd5;
      continuous = 1'b1;
      resp_delay = 3;
      resp_en    = 1'b1;
      push_start(1'b0, b + 2);
      push_start(1'b1, b + 12);
      push_start(1'b0, b + 22);
      push_start(1'b1, b + 32);
      wait_until(b + 32);
      continuous = 1'b0;
      chk("t2_active_cam", {31'd0, active_cam}, 32'd1);
      wait_until(b + 35);
      chk("t2_count", 32'(frame_count), 32'd4);
      wait_until(b + 42);
      chk("t2_idle_state", 32'(dbg_state), 32'd0);
      chk("t2_idle_busy", {31'd0, sched_busy}, 32'd0);
      resp_en = 1'b0;

      // Test 3: cam1 busy window, wrong-camera done ignored
      do_reset();
      b = edge_cnt;
      mode       = 2'b01;
      cam1_busy  = 1'b1;
      sw_trigger = 1'b1;
      push_start(1'b1, b + 9);
      tick();
      sw_trigger = 1'b0;
      wait_until(b + 8);
      chk("t3_start_wait", 32'(dbg_state), 32'd1);
      cam1_busy = 1'b0;
      wait_until(b + 10);
      man_done0 = 1'b1;
      tick();
      man_done0 = 1'b0;
      tick();
      chk("t3_wrong_done_count", 32'(frame_count), 32'd0);
      chk("t3_wrong_done_state", 32'(dbg_state), 32'd2);
      man_done1 = 1'b1;
      tick();
      man_done1 = 1'b0;
      chk("t3_count", 32'(frame_count), 32'd1);
      chk("t3_state_gap", 32'(dbg_state), 32'd3);
      chk("t3_active_cam", {31'd0, active_cam}, 32'd1);

      // Test 4a: enable dropped in WAIT_DONE, frame still completes
      do_reset();
      b = edge_cnt;
      period     = 16'd2;
      continuous = 1'b1;
      push_start(1'b0, b + 2);
      wait_until(b + 3);
      enable = 1'b0;
      wait_until(b + 5);
      man_done0 = 1'b1;
      tick();
      man_done0 = 1'b0;
      chk("t4a_count", 32'(frame_count), 32'd1);
      chk("t4a_state_gap", 32'(dbg_state), 32'd3);
      tick();
      chk("t4a_state_idle", 32'(dbg_state), 32'd0);
      chk("t4a_busy", {31'd0, sched_busy}, 32'd0);
      wait_until(b + 20);
      chk("t4a_count_hold", 32'(frame_count), 32'd1);

      // Test 4b: enable dropped in a long GAP
      do_reset();
      b = edge_cnt;
      period     = 16'd100;
      continuous = 1'b1;
      push_start(1'b0, b + 2);
      wait_until(b + 3);
      man_done0 = 1'b1;
      tick();
      man_done0 = 1'b0;
      wait_until(b + 10);
      chk("t4b_state_gap", 32'(dbg_state), 32'd3);
      enable = 1'b0;
      tick();
      chk("t4b_state_idle", 32'(dbg_state), 32'd0);

      // Test 5: frame_count wrap (8-bit counter)
      do_reset();
      b = edge_cnt;
      continuous = 1'b1;
      resp_delay = 1;
      resp_en    = 1'b1;
      for (int k = 0; k < 256; k++) push_start(1'b0, b + 2 + 3 * k);
      wait_until(b + 3 + 3 * 254);
      chk("t5_count_max", 32'(frame_count), 32'hFF);
      wait_until(b + 767);
      continuous = 1'b0;
      wait_until(b + 768);
      chk("t5_count_wrap", 32'(frame_count), 32'd0);
      wait_until(b + 770);
      chk("t5_state_idle", 32'(dbg_state), 32'd0);
      resp_en = 1'b0;

      // Test 6: done withheld
      do_reset();
      b = edge_cnt;
      sw_trigger = 1'b1;
      push_start(1'b0, b + 2);
      tick();
      sw_trigger = 1'b0;
`ifdef SCHED_TIMEOUT_EN
      wait_until(b + 51);
      chk("t6_err_before", {31'd0, timeout_err}, 32'd0);
      chk("t6_state_wait", 32'(dbg_state), 32'd2);
      tick();
      chk("t6_err_set", {31'd0, timeout_err}, 32'd1);
      chk("t6_count", 32'(frame_count), 32'd0);
      chk("t6_state_gap", 32'(dbg_state), 32'd3);
      wait_until(b + 55);
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      chk("t6_err_clear", {31'd0, timeout_err}, 32'd0);
      chk("t6_state_idle", 32'(dbg_state), 32'd0);
`else
      wait_until(b + 1002);
      chk("t6_state_wait", 32'(dbg_state), 32'd2);
      chk("t6_err", {31'd0, timeout_err}, 32'd0);
      man_done0 = 1'b1;
      tick();
      man_done0 = 1'b0;
      chk("t6_count", 32'(frame_count), 32'd1);
`endif

      // ---------------- report ----------------
      repeat (5) tick();
      chk("missing_starts", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
